// File: rtl/fsrc_trig_shaper.sv
// Per-channel trigger shaper: rising-edge detect, programmable delay, then a
// programmable-width output pulse. Edges arriving while a channel is busy are flagged.
module fsrc_trig_shaper #(
  parameter int NUM_TRIG    = 4,
  parameter int DELAY_WIDTH = 16,
  parameter int PULSE_WIDTH = 8
) (
  input  logic                            clk,
  input  logic                            resetn,
  input  logic                            enable,
  input  logic [NUM_TRIG-1:0]             trig_in,
  input  logic [NUM_TRIG*DELAY_WIDTH-1:0] delay,
  input  logic [NUM_TRIG*PULSE_WIDTH-1:0] width,
  input  logic                            missed_clr,
  output logic [NUM_TRIG-1:0]             trig_out,
  output logic [NUM_TRIG-1:0]             busy,
  output logic [NUM_TRIG-1:0]             missed
);

  localparam int CNT_WIDTH = (DELAY_WIDTH > PULSE_WIDTH) ? DELAY_WIDTH : PULSE_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DELAY = 2'b01,
    ST_PULSE = 2'b10
  } state_e;

  logic [NUM_TRIG-1:0] trig_d_q;
  logic [NUM_TRIG-1:0] rise;

  // Tracks trig_in even while disabled, so re-enabling on a held-high input is not an edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) trig_d_q <= '0;
    else         trig_d_q <= trig_in;
  end

  assign rise = trig_in & ~trig_d_q;

  for (genvar gi = 0; gi < NUM_TRIG; gi++) begin : g_ch
    state_e                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [PULSE_WIDTH-1:0] w_q, w_d;
    logic                   missed_q, missed_d;
    logic [DELAY_WIDTH-1:0] d_in;
    logic [PULSE_WIDTH-1:0] w_in, w_eff;

    assign d_in  = delay[gi*DELAY_WIDTH +: DELAY_WIDTH];
    assign w_in  = width[gi*PULSE_WIDTH +: PULSE_WIDTH];
    assign w_eff = (w_in == '0) ? PULSE_WIDTH'(1) : w_in;

    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      w_d      = w_q;
      missed_d = missed_q;
      if (!enable) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (rise[gi]) begin
              w_d = w_eff;
              if (d_in == '0) begin
                state_d = ST_PULSE;
                cnt_d   = CNT_WIDTH'(w_eff) - CNT_WIDTH'(1);
              end else begin
                state_d = ST_DELAY;
                cnt_d   = CNT_WIDTH'(d_in) - CNT_WIDTH'(1);
              end
            end
          end
          ST_DELAY: begin
            if (cnt_q == '0) begin
              state_d = ST_PULSE;
              cnt_d   = CNT_WIDTH'(w_q) - CNT_WIDTH'(1);
            end else begin
              cnt_d = cnt_q - CNT_WIDTH'(1);
            end
          end
          ST_PULSE: begin
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - CNT_WIDTH'(1);
          end
          default: state_d = ST_IDLE;
        endcase
      end
      // A drop on the same cycle as missed_clr keeps the flag set.
      if (enable && rise[gi] && (state_q != ST_IDLE)) missed_d = 1'b1;
      else if (missed_clr)                            missed_d = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        state_q  <= ST_IDLE;
        cnt_q    <= '0;
        w_q      <= '0;
        missed_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        w_q      <= w_d;
        missed_q <= missed_d;
      end
    end

    assign trig_out[gi] = (state_q == ST_PULSE);
    assign busy[gi]     = (state_q != ST_IDLE);
    assign missed[gi]   = missed_q;
  end

endmodule

// File: tb/tb_fsrc_trig_shaper.sv
// Scoreboard bench for fsrc_trig_shaper: stimulus pushes per-cycle expected
// {trig_out, busy, missed} per channel; a negedge monitor pops and compares.
module tb_fsrc_trig_shaper;
  localparam int NT = 4;
  localparam int DW = 16;
  localparam int PW = 8;

  logic              clk = 1'b0;
  logic              resetn;
  logic              enable;
  logic [NT-1:0]     trig_in;
  logic [NT*DW-1:0]  delay;
  logic [NT*PW-1:0]  width;
  logic              missed_clr;
  logic [NT-1:0]     trig_out;
  logic [NT-1:0]     busy;
  logic [NT-1:0]     missed;

  always #5 clk = ~clk;

  fsrc_trig_shaper #(
    .NUM_TRIG   (NT),
    .DELAY_WIDTH(DW),
    .PULSE_WIDTH(PW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (enable),
    .trig_in   (trig_in),
    .delay     (delay),
    .width     (width),
    .missed_clr(missed_clr),
    .trig_out  (trig_out),
    .busy      (busy),
    .missed    (missed)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    int         ch;
    logic [2:0] exp;
    string      name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void push(input int c, input int ch, input bit t, input bit b,
                               input bit m, input string nm);
    exp_t e;
    e.cyc  = c;
    e.ch   = ch;
    e.exp  = {t, b, m};
    e.name = nm;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t       e;
    logic [2:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      act = {trig_out[e.ch], busy[e.ch], missed[e.ch]};
      n_cmp++;
      if (e.cyc < cyc) begin
        n_bad++;
        $display("FAIL %s ch%0d: expectation for cycle %0d checked late at %0d", e.name, e.ch, e.cyc, cyc);
      end else if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s ch%0d cycle %0d: got trig/busy/missed=%b expected %b",
                 e.name, e.ch, cyc, act, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int ch, input int d, input int w);
    delay[ch*DW +: DW] = DW'(d);
    width[ch*PW +: PW] = PW'(w);
  endtask

  int t0;

  initial begin
    resetn     = 1'b0;
    enable     = 1'b1;
    trig_in    = '0;
    delay      = '0;
    width      = '0;
    missed_clr = 1'b0;

    // Reset state
    tick();
    t0 = cyc;
    for (int ch = 0; ch < NT; ch++) push(t0, ch, 0, 0, 0, "reset");
    tick();
    resetn = 1'b1;
    tick();
    tick();

    // Ch0 D=3 W=2, rise at 10: pulse 14-15, busy 11-15
    t0 = cyc;
    cfg(0, 3, 2);
    for (int r = 0; r < 22; r++)
      push(t0 + r, 0, r >= 14 && r <= 15, r >= 11 && r <= 15, 0, "d3w2");
    for (int r = 0; r < 22; r++) begin
      trig_in[0] = (r == 10);
      tick();
    end

    // Ch1 D=0 W=0, rise at 5 held 20 cycles: single pulse at 6
    t0 = cyc;
    cfg(1, 0, 0);
    for (int r = 0; r < 30; r++)
      push(t0 + r, 1, r == 6, r == 6, 0, "d0w0_hold");
    for (int r = 0; r < 30; r++) begin
      trig_in[1] = (r >= 5 && r <= 24);
      tick();
    end

    // Ch2 D=4 W=4: drops, re-trigger, missed_clr, set-wins-over-clear
    t0 = cyc;
    cfg(2, 4, 4);
    for (int r = 0; r < 36; r++)
      push(t0 + r, 2,
           (r >= 5 && r <= 8) || (r >= 14 && r <= 17) || (r >= 27 && r <= 30),
           (r >= 1 && r <= 8) || (r >= 10 && r <= 17) || (r >= 23 && r <= 30),
           (r >= 7 && r <= 20) || (r >= 25 && r <= 33), "d4w4_missed");
    for (int r = 0; r < 36; r++) begin
      trig_in[2] = (r == 0 || r == 6 || r == 9 || r == 22 || r == 24);
      missed_clr = (r == 20 || r == 24 || r == 33);
      tick();
    end
    missed_clr = 1'b0;

    // Ch3: delay changed 10 -> 2 mid-flight has no effect, pulse 11-13
    t0 = cyc;
    cfg(3, 10, 3);
    for (int r = 0; r < 18; r++)
      push(t0 + r, 3, r >= 11 && r <= 13, r >= 1 && r <= 13, 0, "latched_delay");
    for (int r = 0; r < 18; r++) begin
      trig_in[3] = (r == 0);
      if (r == 3) cfg(3, 2, 3);
      tick();
    end

    // Ch0 D=5 W=5: enable low at 3 aborts; re-enable with trig held gives no pulse
    t0 = cyc;
    cfg(0, 5, 5);
    for (int r = 0; r < 25; r++)
      push(t0 + r, 0, 0, r >= 1 && r <= 3, 0, "enable_abort");
    for (int r = 0; r < 25; r++) begin
      trig_in[0] = (r == 0) || (r >= 6 && r <= 20);
      enable     = !(r >= 3 && r <= 9);
      tick();
    end
    enable = 1'b1;

    // Ch0 D=1 W=10: reset mid-pulse clears asynchronously, then nominal re-trigger
    t0 = cyc;
    cfg(0, 1, 10);
    for (int r = 0; r < 24; r++) begin
      push(t0 + r, 0, (r >= 2 && r <= 4) || (r >= 11 && r <= 20),
           (r >= 1 && r <= 4) || (r >= 10 && r <= 20), 0, "reset_mid_pulse");
      if (r == 5)
        for (int ch = 1; ch < NT; ch++) push(t0 + r, ch, 0, 0, 0, "reset_all");
    end
    for (int r = 0; r < 24; r++) begin
      trig_in[0] = (r == 0 || r == 9);
      resetn     = !(r >= 5 && r <= 6);
      tick();
    end

    for (int i = 0; i < 5 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fsrc_trig_shaper.md
# fsrc_trig_shaper

Per-channel trigger shaper placed directly downstream of the FSRC sequencer's `trig_out` bus. Each channel detects a rising edge on its trigger input, waits a programmable delay, then drives an output pulse of programmable width. This turns single-cycle sequencer triggers into timed, width-controlled strobes for TX/RX datapath consumers. It also flags triggers lost while a channel is busy.

## Interface
- `NUM_TRIG`, 4, number of independent trigger channels
- `DELAY_WIDTH`, 16, width of each per-channel delay value (cycles)
- `PULSE_WIDTH`, 8, width of each per-channel pulse-length value (cycles)

- `clk`  in  1  core clock; the single clock domain of the block
- `resetn`  in  1  asynchronous, active-low reset
- `enable`  in  1  global enable; low forces all channels idle
- `trig_in`  in  NUM_TRIG  trigger inputs from sequencer `trig_out`, synchronous to `clk`
- `delay`  in  NUM_TRIG*DELAY_WIDTH  per-channel delay D; channel i uses bits [i*DELAY_WIDTH +: DELAY_WIDTH]
- `width`  in  NUM_TRIG*PULSE_WIDTH  per-channel pulse length W, packed the same way
- `missed_clr`  in  1  single-cycle pulse that clears all `missed` flags
- `trig_out`  out  NUM_TRIG  shaped trigger pulses
- `busy`  out  NUM_TRIG  channel is in DELAY or PULSE
- `missed`  out  NUM_TRIG  sticky flag: a rising edge was dropped while the channel was busy

## Operation
- Reset (async assert, sync release): every channel goes to IDLE and all counters clear. `trig_out`, `busy`, `missed` and the edge-detect register are all 0.
- Edge detect: `rise[i] = trig_in[i] & ~trig_d[i]`, where `trig_d` is `trig_in` registered. `trig_d` updates every cycle regardless of `enable`.
- Per-channel FSM: IDLE, DELAY, PULSE, driven by a down-counter `cnt` of width max(DELAY_WIDTH, PULSE_WIDTH).
- Latching: D and W are captured when an edge is accepted. Later changes to `delay`/`width` do not affect a channel already in flight.
- W = 0 is treated as W = 1.
- IDLE:
  - On `rise` with `enable`=1 and D = 0: go to PULSE, `cnt` = W'-1.
  - On `rise` with `enable`=1 and D > 0: go to DELAY, `cnt` = D-1.
- DELAY: if `cnt` = 0, go to PULSE with `cnt` = W'-1; otherwise decrement `cnt`.
- PULSE: if `cnt` = 0, go to IDLE; otherwise decrement `cnt`.
- Outputs: `trig_out[i]` = (state == PULSE); `busy[i]` = (state != IDLE). Both decode registered state, so they are glitch-free.
- Dropped edges: a `rise` while in DELAY or PULSE, including the last PULSE cycle, is ignored and sets `missed[i]`.
- `missed` flags hold until `missed_clr`. If a set and `missed_clr` occur in the same cycle, the set wins.
- `enable` low: on the next edge every channel goes to IDLE and `trig_out`/`busy` drop. `missed` is unaffected. A rise while `enable` = 0 is neither accepted nor flagged.
- `enable` rising while `trig_in` is already high does not produce a rise, because `trig_d` keeps tracking while disabled.
- Channels are fully independent; no ordering between channels.

## Timing
- A rise sampled at cycle N (`trig_in` high at N, low at N-1) gives `trig_out` high for cycles N+1+D through N+D+W' inclusive.
- With D = 0, `trig_out` is high at N+1.
- `busy` is high for cycles N+1 through N+D+W'. The channel is IDLE again at N+1+D+W'.
- A rise at cycle N+1+D+W' is accepted. Minimum accepted re-trigger spacing is D+W'+1 cycles.
- Counter arithmetic is unsigned with no wrap: maximum D = 2^DELAY_WIDTH-1, maximum W = 2^PULSE_WIDTH-1.
- `resetn` asserted mid-pulse: `trig_out` goes low asynchronously.
- `missed` goes high one cycle after the offending rise.

## Test plan
- Channel 0, D=3, W=2, single-cycle `trig_in[0]` at cycle 10: `trig_out[0]` high at cycles 14–15, `busy[0]` high 11–15, `missed`=0.
- Channel 1, D=0, W=0: rise at cycle 5 gives a one-cycle `trig_out[1]` at cycle 6. Holding `trig_in[1]` high for 20 cycles produces exactly one pulse.
- Channel 2, D=4, W=4: rises at cycles 0 and 6 give one pulse at 5–8 and `missed[2]`=1 from cycle 7. A rise at cycle 9 is accepted, pulse at 14–17. `missed_clr` at 20 clears the flag at 21. `missed_clr` coincident with a new drop leaves the flag at 1.
- Channel 3: change `delay` from 10 to 2 at cycle 3 after a rise at cycle 0; the pulse still starts at cycle 11.
- Channel 0, D=5, W=5: `enable` dropped at cycle 3 after a rise at 0 gives `busy`=0 at cycle 4 and no pulse. Re-enabling with `trig_in` held high gives no pulse.
- Rise at 0 with D=1, W=10; `resetn` low at cycle 5 gives `trig_out`=0 immediately and all outputs 0. After release, a new rise behaves per the nominal timing.
